// File: rtl/integral_window_gen_pkg.sv
// integral_window_gen_pkg: shared FSM type, window indexing and sum-width helper
package integral_window_gen_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  function automatic int win_idx(input int i, input int j, input int w);
    return j * w + i;
  endfunction
  function automatic int sum_width_min(input int pw, input int fw, input int fh);
    return pw + $clog2(fw * fh);
  endfunction
  localparam int SUM_WIDTH_MIN = sum_width_min(8, 10, 10);
endpackage

// File: rtl/integral_line_buffer.sv
// integral_line_buffer: DEPTH-deep delay line of integral values, advanced per accepted pixel
module integral_line_buffer #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 16
) (
  input  logic             clk_os,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];
  // shift one slot per accepted pixel so q is the value from one row earlier
  always_ff @(posedge clk_os) begin
    if (en) begin
      mem[0] <= d;
      for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
    end
  end
  assign q = mem[DEPTH-1];
endmodule

// File: rtl/integral_window_gen.sv
// integral_window_gen: streaming integral image with a WIN_W x WIN_H sliding output window
module integral_window_gen
  import integral_window_gen_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int SUM_WIDTH   = 16,
  parameter int WIN_W       = 3,
  parameter int WIN_H       = 3,
  parameter int FRAME_W     = 10,
  parameter int FRAME_H     = 10
) (
  input  logic                             clk_os,
  input  logic                             reset_os,
  input  logic [PIXEL_WIDTH-1:0]           pixel,
  input  logic                             wen,
  input  logic                             sof,
  output logic                             o_ready,
  output logic [WIN_W*WIN_H*SUM_WIDTH-1:0] o_integral_image,
  output logic                             o_integral_image_ready,
  input  logic                             win_ack,
  output logic [$clog2(FRAME_W)-1:0]       o_win_x,
  output logic [$clog2(FRAME_H)-1:0]       o_win_y,
  output logic                             o_frame_done
);
  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam logic [XW-1:0] XMAX = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(FRAME_H - 1);
  state_t state, nxt;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [SUM_WIDTH-1:0] rowsum, row_in, ii;
  logic [SUM_WIDTH-1:0] lb_q [WIN_H-1];
  logic [SUM_WIDTH-1:0] above [WIN_H-1];
  logic [SUM_WIDTH-1:0] col [WIN_H];
  logic [SUM_WIDTH-1:0] win [WIN_H][WIN_W];
  logic acc, start, proc, elig, last;
  assign o_ready = !o_integral_image_ready || win_ack;
  assign acc = wen && o_ready;
  assign start = acc && sof;
  assign proc = start || (acc && state == ACTIVE);
  assign px = start ? '0 : x;
  assign py = start ? '0 : y;
  assign row_in = (px == '0 ? '0 : rowsum) + SUM_WIDTH'(pixel);
  assign ii = row_in + above[0];
  assign col[WIN_H-1] = ii;
  assign elig = proc && px >= XW'(WIN_W - 1) && py >= YW'(WIN_H - 1);
  assign last = proc && px == XMAX && py == YMAX;
  genvar k, i, j;
  generate
    for (k = 0; k < WIN_H - 1; k++) begin : g_lb
      if (k == 0) begin : g_first
        integral_line_buffer #(.DEPTH(FRAME_W), .WIDTH(SUM_WIDTH)) u_lb (
          .clk_os(clk_os), .en(proc), .d(ii), .q(lb_q[k]));
      end else begin : g_next
        integral_line_buffer #(.DEPTH(FRAME_W), .WIDTH(SUM_WIDTH)) u_lb (
          .clk_os(clk_os), .en(proc), .d(lb_q[k-1]), .q(lb_q[k]));
      end
      assign above[k] = py > YW'(k) ? lb_q[k] : '0;
      assign col[WIN_H-2-k] = above[k];
    end
    for (j = 0; j < WIN_H; j++) begin : g_row
      for (i = 0; i < WIN_W; i++) begin : g_col
        assign o_integral_image[win_idx(i, j, WIN_W)*SUM_WIDTH +: SUM_WIDTH] = win[j][i];
      end
    end
  endgenerate
  // frame-level state register
  always_ff @(posedge clk_os) begin
    if (!reset_os) state <= IDLE;
    else state <= nxt;
  end
  // start on any accepted sof, flush after the last pixel until the final window is taken
  always_comb begin
    nxt = state;
    if (last) nxt = FLUSH;
    else if (start) nxt = ACTIVE;
    else if (state == FLUSH && o_ready) nxt = IDLE;
  end
  // position, running sum, window shift register and output handshake
  always_ff @(posedge clk_os) begin
    if (!reset_os) begin
      x <= '0;
      y <= '0;
      rowsum <= '0;
      o_integral_image_ready <= 1'b0;
      o_frame_done <= 1'b0;
      o_win_x <= '0;
      o_win_y <= '0;
      for (int r = 0; r < WIN_H; r++)
        for (int c = 0; c < WIN_W; c++) win[r][c] <= '0;
    end else begin
      o_frame_done <= state == FLUSH && o_ready;
      if (acc) o_integral_image_ready <= elig;
      else if (win_ack) o_integral_image_ready <= 1'b0;
      if (proc) begin
        rowsum <= row_in;
        x <= px == XMAX ? '0 : px + 1'b1;
        y <= px == XMAX ? py + 1'b1 : py;
        for (int r = 0; r < WIN_H; r++) begin
          for (int c = 0; c < WIN_W - 1; c++) win[r][c] <= win[r][c+1];
          win[r][WIN_W-1] <= col[r];
        end
      end
      if (elig) begin
        o_win_x <= px;
        o_win_y <= py;
      end
    end
  end
endmodule

// File: tb/tb_integral_window_gen.sv
// tb_integral_window_gen: table-driven frames, hand-written corner sequences and a summing reference model
module tb_integral_window_gen;
  logic clk, reset_os, wen, sof, win_ack;
  logic [7:0] pixel;
  logic ready16, valid16, done16, ready12, valid12, done12;
  logic [143:0] img16;
  logic [107:0] img12;
  logic [3:0] wx16, wy16, wx12, wy12;
  int checks = 0, errors = 0;
  integral_window_gen u_dut (
    .clk_os(clk), .reset_os(reset_os), .pixel(pixel), .wen(wen), .sof(sof),
    .o_ready(ready16), .o_integral_image(img16), .o_integral_image_ready(valid16),
    .win_ack(win_ack), .o_win_x(wx16), .o_win_y(wy16), .o_frame_done(done16));
  integral_window_gen #(.SUM_WIDTH(12)) u_dut12 (
    .clk_os(clk), .reset_os(reset_os), .pixel(pixel), .wen(wen), .sof(sof),
    .o_ready(ready12), .o_integral_image(img12), .o_integral_image_ready(valid12),
    .win_ack(win_ack), .o_win_x(wx12), .o_win_y(wy12), .o_frame_done(done12));
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {int x; int y; logic [143:0] w16; logic [107:0] w12;} exp_t;
  typedef struct {int pat; bit rnd; bit chk; int f0; int f8; int l0; int l8; int l0_12; int l8_12;} vec_t;
  exp_t expq[$];
  exp_t e_cur, e_new;
  int img [10][10];
  bit active = 0;
  int mx = 0, my = 0;
  int win_cnt = 0, done_cnt = 0;
  bit hold_low = 0, rnd_ack = 0, grab = 0;
  int gx, gy;
  logic [143:0] gw, f16, l16;
  logic [107:0] l12;
  longint v;
  task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  function automatic longint ii(input int x, input int y);
    longint s = 0;
    for (int yy = 0; yy <= y; yy++)
      for (int xx = 0; xx <= x; xx++) s += img[yy][xx];
    return s;
  endfunction
  function automatic logic [143:0] exp_ones(input int x, input int y);
    logic [143:0] r = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++) r[(j*3+i)*16 +: 16] = 16'((x - 1 + i) * (y - 1 + j));
    return r;
  endfunction
  // scoreboard: check acknowledged windows, then feed accepted pixels to the model
  always @(negedge clk) begin
    if (valid16 && win_ack) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL window_unexpected got x=%0d y=%0d want none", wx16, wy16);
      end else begin
        e_cur = expq.pop_front();
        chk("win_x", 160'(wx16), 160'(e_cur.x));
        chk("win_y", 160'(wy16), 160'(e_cur.y));
        chk("win16", 160'(img16), 160'(e_cur.w16));
        chk("win12", 160'(img12), 160'(e_cur.w12));
      end
      win_cnt++;
      if (wx16 == 2 && wy16 == 2) f16 = img16;
      if (wx16 == 9 && wy16 == 9) begin l16 = img16; l12 = img12; end
      if (grab) begin grab = 0; gx = wx16; gy = wy16; gw = img16; end
    end
    if (!reset_os) begin
      expq.delete();
      active = 0;
    end else if (wen && ready16) begin
      if (sof) begin active = 1; mx = 0; my = 0; end
      if (active) begin
        img[my][mx] = pixel;
        if (mx >= 2 && my >= 2) begin
          e_new.x = mx;
          e_new.y = my;
          for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++) begin
              v = ii(mx - 2 + i, my - 2 + j);
              e_new.w16[(j*3+i)*16 +: 16] = v[15:0];
              e_new.w12[(j*3+i)*12 +: 12] = v[11:0];
            end
          expq.push_back(e_new);
        end
        if (mx == 9) begin
          mx = 0;
          my++;
          if (my == 10) active = 0;
        end else mx++;
      end
    end
    if (done16) done_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    win_ack = hold_low ? 1'b0 : rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic send_pixel(input logic [7:0] p, input logic s);
    bit a = 0;
    pixel = p;
    sof = s;
    wen = 1;
    for (int n = 0; n < 100 && !a; n++) begin
      @(negedge clk);
      a = ready16;
      tick();
    end
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no acceptance want acceptance within 100 cycles");
    end
    wen = 0;
    sof = 0;
  endtask
  function automatic logic [7:0] pat_val(input int pat, input int x, input int y);
    return pat == 0 ? 8'd1 : pat == 1 ? 8'(x + y) : pat == 2 ? 8'd255 : 8'($urandom_range(0, 255));
  endfunction
  task automatic send_frame(input int pat);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++) send_pixel(pat_val(pat, x, y), x == 0 && y == 0);
  endtask
  task automatic settle();
    rnd_ack = 0;
    hold_low = 0;
    repeat (6) tick();
  endtask
  vec_t vecs [4];
  initial begin
    vecs[0] = '{0, 0, 1, 1, 9, 64, 100, 64, 100};
    vecs[1] = '{1, 0, 1, 0, 18, 448, 900, 448, 900};
    vecs[2] = '{2, 0, 1, 255, 2295, 16320, 25500, 4032, 924};
    vecs[3] = '{3, 1, 0, 0, 0, 0, 0, 0, 0};
    reset_os = 0; wen = 0; sof = 0; pixel = 0; win_ack = 1;
    tick(); tick();
    reset_os = 1;
    @(negedge clk);
    chk("rst_ready", 160'(ready16), 160'(1));
    chk("rst_valid", 160'(valid16), 160'(0));
    chk("rst_done", 160'(done16), 160'(0));
    chk("rst_xy", 160'({wx16, wy16}), 160'(0));
    chk("rst_img16", 160'(img16), 160'(0));
    chk("rst_img12", 160'(img12), 160'(0));
    for (int t = 0; t < 4; t++) begin
      win_cnt = 0; done_cnt = 0; f16 = '0; l16 = '0; l12 = '0;
      rnd_ack = vecs[t].rnd;
      send_frame(vecs[t].pat);
      settle();
      chk($sformatf("frame%0d_windows", t), 160'(win_cnt), 160'(64));
      chk($sformatf("frame%0d_done", t), 160'(done_cnt), 160'(1));
      chk($sformatf("frame%0d_pending", t), 160'(expq.size()), 160'(0));
      if (vecs[t].chk) begin
        chk($sformatf("frame%0d_first0", t), 160'(f16[15:0]), 160'(vecs[t].f0));
        chk($sformatf("frame%0d_first8", t), 160'(f16[143:128]), 160'(vecs[t].f8));
        chk($sformatf("frame%0d_last0", t), 160'(l16[15:0]), 160'(16'(vecs[t].l0)));
        chk($sformatf("frame%0d_last8", t), 160'(l16[143:128]), 160'(16'(vecs[t].l8)));
        chk($sformatf("frame%0d_last0_12", t), 160'(l12[11:0]), 160'(vecs[t].l0_12));
        chk($sformatf("frame%0d_last8_12", t), 160'(l12[107:96]), 160'(vecs[t].l8_12));
      end
    end
    win_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 44; n++) send_pixel(8'd1, n == 0);
    hold_low = 1;
    send_pixel(8'd1, 1'b0);
    pixel = 8'd1;
    wen = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_ready", 160'(ready16), 160'(0));
      chk("stall_valid", 160'(valid16), 160'(1));
      chk("stall_xy", 160'({wx16, wy16}), 160'({4'd4, 4'd4}));
      chk("stall_img", 160'(img16), 160'(exp_ones(4, 4)));
      if (n == 4) hold_low = 0;
      tick();
    end
    send_pixel(8'd1, 1'b0);
    @(negedge clk);
    chk("after_stall_xy", 160'({valid16, wx16, wy16}), 160'({1'b1, 4'd5, 4'd4}));
    for (int n = 46; n < 100; n++) send_pixel(8'd1, 1'b0);
    settle();
    chk("stall_windows", 160'(win_cnt), 160'(64));
    chk("stall_done", 160'(done_cnt), 160'(1));
    win_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 36; n++) send_pixel(8'd1, n == 0);
    send_pixel(8'd1, 1'b1);
    grab = 1;
    for (int n = 1; n < 100; n++) send_pixel(8'd1, 1'b0);
    settle();
    chk("abort_first_xy", 160'({gx[3:0], gy[3:0]}), 160'({4'd2, 4'd2}));
    chk("abort_first_img", 160'(gw), 160'(exp_ones(2, 2)));
    chk("abort_windows", 160'(win_cnt), 160'(76));
    chk("abort_done", 160'(done_cnt), 160'(1));
    win_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 56; n++) send_pixel(8'd1, n == 0);
    reset_os = 0;
    tick();
    reset_os = 1;
    @(negedge clk);
    chk("midrst_ready", 160'(ready16), 160'(1));
    chk("midrst_valid", 160'(valid16), 160'(0));
    chk("midrst_xy", 160'({wx16, wy16}), 160'(0));
    chk("midrst_img", 160'(img16), 160'(0));
    chk("midrst_done", 160'(done16), 160'(0));
    for (int n = 0; n < 10; n++) send_pixel(8'd1, 1'b0);
    settle();
    chk("idle_windows", 160'(win_cnt), 160'(28));
    chk("idle_valid", 160'(valid16), 160'(0));
    send_frame(0);
    settle();
    chk("post_rst_windows", 160'(win_cnt), 160'(92));
    chk("post_rst_done", 160'(done_cnt), 160'(1));
    chk("post_rst_pending", 160'(expq.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/integral_window_gen.md
INTEGRAL_WINDOW_GEN -- requirements
Module: integral_window_gen

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: width of the input pixel.
REQ-002 Parameter SUM_WIDTH, default 16: width of each integral value.
REQ-003 Parameter WIN_W, default 3: window width in pixels, at least 2.
REQ-004 Parameter WIN_H, default 3: window height in rows, at least 2.
REQ-005 Parameter FRAME_W, default 10: frame width; FRAME_W >= WIN_W.
REQ-006 Parameter FRAME_H, default 10: frame height; FRAME_H >= WIN_H.
REQ-007 Clock and reset: one clock; reset is synchronous and active-low.
REQ-008 clk_os  in  1  sole clock, all state on its rising edge.
REQ-009 reset_os  in  1  synchronous active-low reset.
REQ-010 pixel  in  PIXEL_WIDTH  raster-order pixel.
REQ-011 wen  in  1  pixel valid.
REQ-012 sof  in  1  qualifies the pixel carrying wen as frame position (0,0).
REQ-013 o_ready  out  1  block accepts a pixel this cycle.
REQ-014 o_integral_image  out  WIN_W*WIN_H*SUM_WIDTH  flattened window; element j*WIN_W+i at bits [(j*WIN_W+i+1)*SUM_WIDTH-1 -: SUM_WIDTH].
REQ-015 o_integral_image_ready  out  1  window valid.
REQ-016 win_ack  in  1  downstream consumes the window.
REQ-017 o_win_x, o_win_y  out  $clog2(FRAME_W), $clog2(FRAME_H)  frame coordinate of the window's bottom-right pixel.
REQ-018 o_frame_done  out  1  one-cycle pulse after the last frame pixel is accepted.

Function
REQ-019 A pixel is accepted when wen and o_ready are both high; o_ready is !o_integral_image_ready || win_ack.
REQ-020 The block SHALL compute II(x,y), the sum of all pixels (x'<=x, y'<=y) of the current frame, as row running sum plus II(x,y-1), modulo 2^SUM_WIDTH.
REQ-021 II(x,y-1) SHALL come from line buffers holding WIN_H-1 previous rows of FRAME_W integral values each; row -1 and column -1 read as 0.
REQ-022 The window element j*WIN_W+i SHALL equal II(x-WIN_W+1+i, y-WIN_H+1+j) for accepted pixel (x,y).
REQ-023 o_integral_image_ready SHALL rise on the cycle after accepting pixel (x,y) with x>=WIN_W-1 and y>=WIN_H-1 (latency 1); it SHALL remain high with the outputs stable until win_ack.
REQ-024 FSM states: IDLE, ACTIVE, FLUSH.
REQ-025 IDLE: pixels without sof are accepted and dropped; an accepted pixel with sof moves to ACTIVE at (0,0).
REQ-026 ACTIVE: x increments per accepted pixel, wraps to 0 at FRAME_W-1, and y then increments; acceptance of (FRAME_W-1,FRAME_H-1) moves to FLUSH.
REQ-027 FLUSH: wait until the final window is acknowledged, pulse o_frame_done for one cycle, then return to IDLE.
REQ-028 An accepted sof in ACTIVE SHALL abort the frame: clear the running sum, mark line buffers as row -1 and restart at (0,0) with that pixel; any pending window is discarded.
REQ-029 Simultaneous win_ack and a new acceptance SHALL replace the window in the same cycle without a bubble.

Reset
REQ-030 While reset_os is low at a clock edge: FSM to IDLE; x, y, running sum to 0; o_integral_image_ready, o_frame_done, o_win_x, o_win_y and o_integral_image to 0; o_ready to 1 after release.
REQ-031 Reset asserted mid-frame SHALL discard the frame; line-buffer contents need not be cleared because the row -1 marking masks them.

Structure
REQ-032 Shared package: FSM state enum, window index function, and a SUM_WIDTH sufficiency constant (PIXEL_WIDTH+clog2(FRAME_W*FRAME_H)).
REQ-033 One sub-module, integral_line_buffer: a FRAME_W-deep, SUM_WIDTH-wide delay line instanced WIN_H-1 times, advancing only on acceptance.

Verification
REQ-034 10x10 all-ones frame with 3x3 window -> first valid after (2,2) with elements [0]=1 and [8]=9; last at (9,9) with [0]=64 and [8]=100; o_frame_done pulses once.
REQ-035 Pixel value x+y, win_ack held high -> every window matches the reference model; 64 windows, one per accepted eligible pixel.
REQ-036 win_ack held low for 5 cycles at window (4,4) -> o_ready low, outputs stable, no pixel lost, next window is (5,4).
REQ-037 sof reasserted at (6,3) -> next windows restart at (2,2) with all-ones values [8]=9.
REQ-038 reset_os low for 1 cycle at (5,5) -> all outputs 0, FSM IDLE, non-sof pixels ignored until the next sof.
REQ-039 All pixels 255 with SUM_WIDTH=12 -> II wraps modulo 4096; II(9,9)=25500 mod 4096=924.
